condicionador_botoes: RTL and testbench

Conditions the seven raw note buttons before they reach the game datapath. Each input passes through a two-flop synchronizer, and the whole 7-bit vector is debounced as a single unit by a four-state FSM. The block emits a stable, one-hot-checked `botoes` vector, a one-cycle press pulse and a multi-press flag. It sits directly upstream of `fluxo_dados`, whose `botoes` input it drives.

---
 rtl/condicionador_botoes_pkg.sv | 26 ++
 rtl/sincronizador_2ff.sv | 29 ++
 rtl/condicionador_botoes.sv | 124 ++++++++++++
 tb/tb_condicionador_botoes.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/condicionador_botoes_pkg.sv
// Purpose: shared constants, FSM state encoding and one-hot helper for the button conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pacote_botoes;

    localparam int NUM_BOTOES = 7;

    // Debounce FSM states; the encoding is exported on db_estado.
    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        CONFIRMA    = 2'd1,
        PRESSIONADO = 2'd2,
        SOLTANDO    = 2'd3
    } estado_t;

    // True when exactly one bit of the vector is set.
    function automatic logic eh_one_hot(input logic [NUM_BOTOES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_BOTOES; i++) begin
            n += int'(v[i]);
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Purpose: two-flop synchronizer bringing asynchronous levels into the clock domain.
// Latency: 2 cycles from input to q.
// Backpressure: none; free-running level path.
// Ports: clock, reset_n (async active-low), d[WIDTH] async in, q[WIDTH] synchronized out.
module sincronizador_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Purpose: synchronizes and debounces the 7 note buttons as one vector; flags single/multi presses.
// Latency: DEBOUNCE_CICLOS+2 cycles from a stable raw press/release to botoes.
// Backpressure: none; outputs are registered levels plus a one-cycle press pulse.
// Ports: clock, reset_n (async active-low), botoes_brutos[7] raw levels, habilita gates the pulse;
//        botoes[7] debounced one-hot vector, tem_botao, pulso_pressao, multiplos, db_estado[2].
module condicionador_botoes
    import pacote_botoes::*;
#(
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_BOTOES-1:0] botoes_brutos,
    input  logic                  habilita,
    output logic [NUM_BOTOES-1:0] botoes,
    output logic                  tem_botao,
    output logic                  pulso_pressao,
    output logic                  multiplos,
    output logic [1:0]            db_estado
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    logic [NUM_BOTOES-1:0] s2;

    estado_t               estado_q,   estado_d;
    logic [NUM_BOTOES-1:0] candidato_q, candidato_d;
    logic [NUM_BOTOES-1:0] estavel_q,  estavel_d;
    logic [CW-1:0]         cnt_q,      cnt_d;
    logic                  pulso_q,    pulso_d;

    sincronizador_2ff #(
        .WIDTH (NUM_BOTOES)
    ) u_sinc (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (botoes_brutos),
        .q       (s2)
    );

    always_comb begin
        estado_d    = estado_q;
        candidato_d = candidato_q;
        estavel_d   = estavel_q;
        cnt_d       = cnt_q;
        pulso_d     = 1'b0;   // pulse lives exactly one cycle

        case (estado_q)
            SOLTO: begin
                estavel_d = '0;
                if (s2 != '0) begin
                    candidato_d = s2;
                    cnt_d       = '0;
                    estado_d    = CONFIRMA;
                end
            end
            CONFIRMA: begin
                if (s2 == '0) begin
                    estado_d = SOLTO;
                end else if (s2 != candidato_q) begin
                    // Chord still settling: restart on the new pattern.
                    candidato_d = s2;
                    cnt_d       = '0;
                end else if (cnt_q == CNT_MAX) begin
                    estavel_d = candidato_q;
                    estado_d  = PRESSIONADO;
                    pulso_d   = eh_one_hot(candidato_q) && habilita;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSIONADO: begin
                if (s2 != estavel_q) begin
                    cnt_d    = '0;
                    estado_d = SOLTANDO;
                end
            end
            SOLTANDO: begin
                if (s2 == estavel_q) begin
                    // Release glitch: return without a new pulse.
                    estado_d = PRESSIONADO;
                end else if (cnt_q == CNT_MAX) begin
                    estavel_d = '0;
                    if (s2 == '0) begin
                        estado_d = SOLTO;
                    end else begin
                        // Changed chord: the new pattern must confirm from scratch.
                        candidato_d = s2;
                        cnt_d       = '0;
                        estado_d    = CONFIRMA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: estado_d = SOLTO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q    <= SOLTO;
            candidato_q <= '0;
            estavel_q   <= '0;
            cnt_q       <= '0;
            pulso_q     <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            candidato_q <= candidato_d;
            estavel_q   <= estavel_d;
            cnt_q       <= cnt_d;
            pulso_q     <= pulso_d;
        end
    end

    // Output decode from registers only; multi-key chords never reach the datapath.
    assign botoes        = eh_one_hot(estavel_q) ? estavel_q : '0;
    assign tem_botao     = (estavel_q != '0);
    assign multiplos     = (estavel_q != '0) && !eh_one_hot(estavel_q);
    assign pulso_pressao = pulso_q;
    assign db_estado     = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Purpose: self-checking bench for condicionador_botoes with DEBOUNCE_CICLOS = 4.
// Latency: expectations derived from raw-input change to output (D+3 ticks incl. capture edge).
// Backpressure: n/a.
module tb_condicionador_botoes;
    import pacote_botoes::*;

    localparam int D   = 4;
    // Ticks counted from the first edge after the input changes (that edge loads s1):
    // s2 at tick 2, CONFIRMA/SOLTANDO entered at tick 3, commit at tick D+3.
    localparam int LAT = D + 3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [6:0] botoes_brutos;
    logic       habilita;
    logic [6:0] botoes;
    logic       tem_botao;
    logic       pulso_pressao;
    logic       multiplos;
    logic [1:0] db_estado;

    always #5 clock = ~clock;

    condicionador_botoes #(
        .DEBOUNCE_CICLOS (D)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .botoes_brutos (botoes_brutos),
        .habilita      (habilita),
        .botoes        (botoes),
        .tem_botao     (tem_botao),
        .pulso_pressao (pulso_pressao),
        .multiplos     (multiplos),
        .db_estado     (db_estado)
    );

    // One phase of stimulus: inputs held for 'ciclos' ticks; outputs switch to the
    // expected values after tick 'lat' (0 = outputs keep their previous values).
    typedef struct {
        string      nome;
        logic [6:0] brutos;
        logic       hab;
        int         ciclos;
        int         lat;
        logic [6:0] e_botoes;
        logic       e_tem;
        logic       e_mult;
        logic       e_pulso;
        logic [1:0] e_est;
    } linha_t;

    typedef struct {
        string      nome;
        int         tick;
        logic [6:0] botoes;
        logic       tem;
        logic       mult;
        logic       pulso;
        logic       chk_est;
        logic [1:0] est;
    } esperado_t;

    linha_t    tab[$];
    esperado_t sb[$];
    int        n_aval   = 0;
    int        n_falhas = 0;
    logic [6:0] ant_botoes;
    logic       ant_tem;
    logic       ant_mult;

    function automatic linha_t mk(input string nome, input logic [6:0] brutos, input logic hab,
                                  input int ciclos, input int lat, input logic [6:0] eb,
                                  input logic et, input logic em, input logic ep,
                                  input logic [1:0] ee);
        linha_t l;
        l.nome = nome; l.brutos = brutos; l.hab = hab; l.ciclos = ciclos; l.lat = lat;
        l.e_botoes = eb; l.e_tem = et; l.e_mult = em; l.e_pulso = ep; l.e_est = ee;
        return l;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic confere();
        esperado_t e;
        n_aval++;
        if (sb.size() == 0) begin
            n_falhas++;
            $display("FAIL scoreboard_empty: no expectation queued for a DUT output cycle");
            return;
        end
        e = sb.pop_front();
        if (botoes !== e.botoes || tem_botao !== e.tem || multiplos !== e.mult ||
            pulso_pressao !== e.pulso || (e.chk_est && db_estado !== e.est)) begin
            n_falhas++;
            $display("FAIL %s tick %0d: got botoes=%b tem=%b mult=%b pulso=%b est=%0d, want botoes=%b tem=%b mult=%b pulso=%b est=%0d(chk=%b)",
                     e.nome, e.tick, botoes, tem_botao, multiplos, pulso_pressao, db_estado,
                     e.botoes, e.tem, e.mult, e.pulso, e.est, e.chk_est);
        end
    endtask

    task automatic confere_zero(input string nome);
        n_aval++;
        if (botoes !== 7'd0 || tem_botao !== 1'b0 || multiplos !== 1'b0 ||
            pulso_pressao !== 1'b0 || db_estado !== 2'd0) begin
            n_falhas++;
            $display("FAIL %s: got botoes=%b tem=%b mult=%b pulso=%b est=%0d, want all zero",
                     nome, botoes, tem_botao, multiplos, pulso_pressao, db_estado);
        end
    endtask

    task automatic roda(input linha_t l);
        esperado_t e;
        logic      novo;
        botoes_brutos = l.brutos;
        habilita      = l.hab;
        for (int k = 1; k <= l.ciclos; k++) begin
            novo      = (l.lat != 0) && (k >= l.lat);
            e.nome    = l.nome;
            e.tick    = k;
            e.botoes  = novo ? l.e_botoes : ant_botoes;
            e.tem     = novo ? l.e_tem    : ant_tem;
            e.mult    = novo ? l.e_mult   : ant_mult;
            e.pulso   = l.e_pulso && (k == l.lat);
            e.chk_est = (k == l.ciclos);
            e.est     = l.e_est;
            sb.push_back(e);
            tick();
            confere();
        end
        if (l.lat != 0) begin
            ant_botoes = l.e_botoes;
            ant_tem    = l.e_tem;
            ant_mult   = l.e_mult;
        end
    endtask

    initial begin
        // name, raw, hab, cycles, lat, botoes, tem, mult, pulse, final state
        tab.push_back(mk("press_limpo",  7'b0000100, 1'b1, 20, LAT, 7'b0000100, 1'b1, 1'b0, 1'b1, PRESSIONADO));
        tab.push_back(mk("solta_limpo",  7'b0000000, 1'b1, 20, LAT, 7'b0000000, 1'b0, 1'b0, 1'b0, SOLTO));
        tab.push_back(mk("quique_1a",    7'b0000001, 1'b1,  2,   0, 7'b0000000, 1'b0, 1'b0, 1'b0, SOLTO));
        tab.push_back(mk("quique_0a",    7'b0000000, 1'b1,  2,   0, 7'b0000000, 1'b0, 1'b0, 1'b0, CONFIRMA));
        tab.push_back(mk("quique_1b",    7'b0000001, 1'b1,  2,   0, 7'b0000000, 1'b0, 1'b0, 1'b0, SOLTO));
        tab.push_back(mk("quique_0b",    7'b0000000, 1'b1,  2,   0, 7'b0000000, 1'b0, 1'b0, 1'b0, CONFIRMA));
        tab.push_back(mk("quique_fixa",  7'b0000001, 1'b1, 20, LAT, 7'b0000001, 1'b1, 1'b0, 1'b1, PRESSIONADO));
        tab.push_back(mk("quique_solta", 7'b0000000, 1'b1, 20, LAT, 7'b0000000, 1'b0, 1'b0, 1'b0, SOLTO));
        tab.push_back(mk("glitch_press", 7'b0100000, 1'b1, 20, LAT, 7'b0100000, 1'b1, 1'b0, 1'b1, PRESSIONADO));
        tab.push_back(mk("glitch_zero",  7'b0000000, 1'b1,  2,   0, 7'b0000000, 1'b0, 1'b0, 1'b0, PRESSIONADO));
        tab.push_back(mk("glitch_volta", 7'b0100000, 1'b1, 10,   0, 7'b0000000, 1'b0, 1'b0, 1'b0, PRESSIONADO));
        tab.push_back(mk("glitch_solta", 7'b0000000, 1'b1, 20, LAT, 7'b0000000, 1'b0, 1'b0, 1'b0, SOLTO));
        tab.push_back(mk("multi_press",  7'b0000011, 1'b1, 20, LAT, 7'b0000000, 1'b1, 1'b1, 1'b0, PRESSIONADO));
        tab.push_back(mk("multi_troca",  7'b0000010, 1'b1,  7, LAT, 7'b0000000, 1'b0, 1'b0, 1'b0, CONFIRMA));
        tab.push_back(mk("multi_conf",   7'b0000010, 1'b1, 13,   D, 7'b0000010, 1'b1, 1'b0, 1'b1, PRESSIONADO));
        tab.push_back(mk("multi_solta",  7'b0000000, 1'b1, 20, LAT, 7'b0000000, 1'b0, 1'b0, 1'b0, SOLTO));
        tab.push_back(mk("hab0_press",   7'b1000000, 1'b0, 20, LAT, 7'b1000000, 1'b1, 1'b0, 1'b0, PRESSIONADO));
        tab.push_back(mk("hab0_solta",   7'b0000000, 1'b0, 20, LAT, 7'b0000000, 1'b0, 1'b0, 1'b0, SOLTO));
        // habilita low while confirming, high only on the committing edge
        tab.push_back(mk("habc_espera",  7'b0000100, 1'b0,  6,   0, 7'b0000000, 1'b0, 1'b0, 1'b0, CONFIRMA));
        tab.push_back(mk("habc_commit",  7'b0000100, 1'b1, 10,   1, 7'b0000100, 1'b1, 1'b0, 1'b1, PRESSIONADO));
        tab.push_back(mk("habc_solta",   7'b0000000, 1'b1, 20, LAT, 7'b0000000, 1'b0, 1'b0, 1'b0, SOLTO));

        reset_n       = 1'b0;
        botoes_brutos = 7'd0;
        habilita      = 1'b0;
        ant_botoes    = 7'd0;
        ant_tem       = 1'b0;
        ant_mult      = 1'b0;
        repeat (2) tick();
        confere_zero("reset_inicial");
        reset_n = 1'b1;

        for (int i = 0; i < tab.size(); i++) begin
            roda(tab[i]);
        end

        // Reset in the middle of a confirmation, input kept pressed.
        botoes_brutos = 7'b0001000;
        habilita      = 1'b1;
        repeat (4) tick();
        n_aval++;
        if (db_estado !== 2'(CONFIRMA) || botoes !== 7'd0) begin
            n_falhas++;
            $display("FAIL pre_reset_confirma: got est=%0d botoes=%b, want est=1 botoes=0000000",
                     db_estado, botoes);
        end
        reset_n = 1'b0;
        #1;
        confere_zero("reset_meio_confirma");
        tick();
        confere_zero("reset_mantido");
        reset_n    = 1'b1;
        ant_botoes = 7'd0;
        ant_tem    = 1'b0;
        ant_mult   = 1'b0;
        roda(mk("pos_reset",       7'b0001000, 1'b1, 20, LAT, 7'b0001000, 1'b1, 1'b0, 1'b1, PRESSIONADO));
        roda(mk("pos_reset_solta", 7'b0000000, 1'b1, 20, LAT, 7'b0000000, 1'b0, 1'b0, 1'b0, SOLTO));

        n_aval++;
        if (sb.size() != 0) begin
            n_falhas++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
